// File: rtl/dps_irq_arbiter_pkg.sv
// Shared constants for the DPS interrupt arbiter: state encodings,
// default source count and the data-reset switch for the level field.
package dps_irq_arbiter_pkg;

    localparam logic DPS_IRQ_ARB_STT_IDLE     = 1'b0;
    localparam logic DPS_IRQ_ARB_STT_ACK_WAIT = 1'b1;

    // Default number of interrupt sources
    localparam int DPS_IRQ_ARB_IRQ_N = 4;

    // When set, the per-source level field is cleared by reset
    localparam bit DATA_RESET_ENABLE = 1'b1;

    typedef enum logic {
        ST_IDLE     = DPS_IRQ_ARB_STT_IDLE,
        ST_ACK_WAIT = DPS_IRQ_ARB_STT_ACK_WAIT
    } arb_state_e;

endpackage

// File: rtl/dps_irq_arbiter_pick.sv
// Combinational winner pick: highest level among eligible sources, then the
// first eligible index at or after rr_ptr (wrapping) within that level.
// With all levels equal this degenerates to plain round-robin.
module dps_irq_arbiter_pick
    import dps_irq_arbiter_pkg::*;
#(
    parameter int IRQ_N   = DPS_IRQ_ARB_IRQ_N,
    parameter int IRQ_N_W = 2
) (
    input  logic [IRQ_N-1:0]       elig,
    input  logic [IRQ_N-1:0][1:0]  level,
    input  logic [IRQ_N_W-1:0]     rr_ptr,
    output logic                   win_vld,
    output logic [IRQ_N_W-1:0]     win_idx,
    output logic [1:0]             win_lvl
);

    // Find the top eligible level, then scan from rr_ptr for the first match
    always_comb begin
        logic [1:0]         top;
        logic [IRQ_N_W-1:0] sel;
        top     = '0;
        sel     = '0;
        win_vld = 1'b0;
        win_idx = '0;
        win_lvl = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (elig[i] && (level[i] > top))
                top = level[i];
        end
        for (int k = 0; k < IRQ_N; k++) begin
            sel = IRQ_N_W'((int'(rr_ptr) + k) % IRQ_N);
            if (!win_vld && elig[sel] && (level[sel] == top)) begin
                win_vld = 1'b1;
                win_idx = sel;
                win_lvl = top;
            end
        end
    end

endmodule

// File: rtl/dps_irq_arbiter.sv
// DPS interrupt arbiter: per-source config table (valid/mask/level), level
// priority with round-robin tiebreak, valid/ack delivery to the core and a
// one-cycle capture acknowledge back to the winning source.
// Optional feature macro: DPS_IRQ_ARB_LEVEL_EN (level priority). Without it
// selection is pure round-robin, no level storage, oIRQ_LEVEL is 0.
module dps_irq_arbiter
    import dps_irq_arbiter_pkg::*;
#(
    parameter int IRQ_N   = DPS_IRQ_ARB_IRQ_N,
    parameter int IRQ_N_W = 2
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iCFG_REQ,
    input  logic [IRQ_N_W-1:0] iCFG_ENTRY,
    input  logic               iCFG_MASK,
    input  logic               iCFG_VALID,
    input  logic [1:0]         iCFG_LEVEL,
    input  logic [IRQ_N-1:0]   iIRQ_REQ,
    output logic [IRQ_N-1:0]   oIRQ_SRC_ACK,
    output logic               oIRQ_VALID,
    output logic [IRQ_N_W-1:0] oIRQ_NUM,
    output logic [1:0]         oIRQ_LEVEL,
    input  logic               iIRQ_ACK
);

    arb_state_e                state;
    logic [IRQ_N-1:0]          valid_q;
    logic [IRQ_N-1:0]          mask_q;
    logic [IRQ_N-1:0][1:0]     level_vec;
    logic [IRQ_N-1:0]          elig;
    logic [IRQ_N_W-1:0]        rr_ptr;
    logic                      win_vld;
    logic [IRQ_N_W-1:0]        win_idx;
    logic [1:0]                win_lvl;
    logic                      irq_valid;
    logic [IRQ_N_W-1:0]        irq_num;
    logic [1:0]                irq_level;
    logic                      cfg_wr;

    // Out-of-range entries are dropped silently
    assign cfg_wr = iCFG_REQ && (int'(iCFG_ENTRY) < IRQ_N);

    // Valid/mask table; an invalid entry leaves the source unconditionally enabled
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            valid_q <= '0;
            mask_q  <= '0;
        end else if (cfg_wr) begin
            valid_q[iCFG_ENTRY] <= iCFG_VALID;
            mask_q[iCFG_ENTRY]  <= iCFG_MASK;
        end
    end

`ifdef DPS_IRQ_ARB_LEVEL_EN
    logic [IRQ_N-1:0][1:0] level_q;

    generate
        if (DATA_RESET_ENABLE) begin : g_lvl_rst
            // Level table, cleared by reset
            always_ff @(posedge iCLOCK or negedge inRESET) begin
                if (!inRESET)
                    level_q <= '0;
                else if (cfg_wr)
                    level_q[iCFG_ENTRY] <= iCFG_LEVEL;
            end
        end else begin : g_lvl_nrst
            // Level table, data-only (no reset)
            always_ff @(posedge iCLOCK) begin
                if (cfg_wr)
                    level_q[iCFG_ENTRY] <= iCFG_LEVEL;
            end
        end
    endgenerate

    assign level_vec = level_q;
`else
    // Levels are not stored; all sources compete at level 0
    logic cfg_level_unused;
    assign cfg_level_unused = ^iCFG_LEVEL;
    assign level_vec        = '0;
`endif

    assign elig = iIRQ_REQ & (~valid_q | mask_q);

    dps_irq_arbiter_pick #(
        .IRQ_N   (IRQ_N),
        .IRQ_N_W (IRQ_N_W)
    ) u_pick (
        .elig    (elig),
        .level   (level_vec),
        .rr_ptr  (rr_ptr),
        .win_vld (win_vld),
        .win_idx (win_idx),
        .win_lvl (win_lvl)
    );

    // Capture/present FSM: latch winner in IDLE, hold it until the core acks
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            irq_valid <= 1'b0;
            irq_num   <= '0;
            irq_level <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        state     <= ST_ACK_WAIT;
                        irq_valid <= 1'b1;
                        irq_num   <= win_idx;
                        irq_level <= win_lvl;
                        rr_ptr    <= (int'(win_idx) == IRQ_N - 1) ? '0
                                                                  : win_idx + IRQ_N_W'(1);
                    end
                end
                ST_ACK_WAIT: begin
                    if (iIRQ_ACK) begin
                        state     <= ST_IDLE;
                        irq_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Source acknowledge pulses in the capture cycle; forced low during reset
    always_comb begin
        oIRQ_SRC_ACK = '0;
        if (inRESET && (state == ST_IDLE) && win_vld)
            oIRQ_SRC_ACK[win_idx] = 1'b1;
    end

    assign oIRQ_VALID = irq_valid;
    assign oIRQ_NUM   = irq_num;
    assign oIRQ_LEVEL = irq_level;

endmodule

// File: doc/dps_irq_arbiter.md
# dps_irq_arbiter

Interrupt arbiter and scheduler for the DPS interrupt path. It generalises the fixed two-source IRQ check to `IRQ_N` sources. It holds a per-source configuration table (valid, mask, 2-bit level) and selects one eligible source by level priority, with a round-robin tiebreak inside a level. It delivers the winner to the core through a valid/ack handshake and acknowledges the source when it is captured.

## Interface
- `IRQ_N`, 4, number of interrupt sources (2..16)
- `IRQ_N_W`, 2, index width; must equal clog2(`IRQ_N`)
- `iCLOCK`  in  1  clock
- `inRESET`  in  1  reset, asynchronous, active-low
- `iCFG_REQ`  in  1  config table write strobe
- `iCFG_ENTRY`  in  `IRQ_N_W`  table index written
- `iCFG_MASK`  in  1  mask bit; 1 = source enabled when entry valid
- `iCFG_VALID`  in  1  entry valid; 0 = source unconditionally enabled
- `iCFG_LEVEL`  in  2  priority level, 3 highest
- `iIRQ_REQ`  in  `IRQ_N`  per-source level-sensitive request
- `oIRQ_SRC_ACK`  out  `IRQ_N`  one-hot capture acknowledge, 1-cycle pulse
- `oIRQ_VALID`  out  1  interrupt presented to core
- `oIRQ_NUM`  out  `IRQ_N_W`  presented source index
- `oIRQ_LEVEL`  out  2  presented source level
- `iIRQ_ACK`  in  1  core accepts presented interrupt

## Operation
- Table reset values: valid=0, mask=0, level=0. At reset every source is eligible at level 0.
- Table write: on `iCFG_REQ`, the entry `iCFG_ENTRY` is overwritten at the clock edge. An `iCFG_ENTRY` value of `IRQ_N` or above is ignored.
- Eligibility: source i is eligible when `iIRQ_REQ[i]` is high and either valid[i] is 0 or mask[i] is 1.
- Selection:
  - The highest level among eligible sources wins.
  - Among sources at that level, the winner is the first eligible index at or after `rr_ptr`, wrapping modulo `IRQ_N`.
- States: IDLE and ACK_WAIT.
  - IDLE: if any source is eligible, the winner's index and level are latched and the state moves to ACK_WAIT. In the same cycle `oIRQ_SRC_ACK[winner]` is high (combinational from IDLE and the winner). `rr_ptr` becomes (winner+1) mod `IRQ_N`.
  - ACK_WAIT: `oIRQ_VALID` is 1. On `iIRQ_ACK` the state returns to IDLE. `oIRQ_NUM` and `oIRQ_LEVEL` stay stable until then.
- `iIRQ_ACK` is ignored in IDLE.
- Reset values of outputs: `oIRQ_VALID`=0, `oIRQ_NUM`=0, `oIRQ_LEVEL`=0, `oIRQ_SRC_ACK`=0. `rr_ptr` resets to 0 and the state to IDLE.
- A reset asserted mid-handshake drops the pending interrupt. It is not replayed.
- A config write during ACK_WAIT does not alter the presented interrupt.
- Sources must deassert `iIRQ_REQ` after their acknowledge. A request still held is re-arbitrated as a new interrupt.

## Timing
- Selection uses table contents registered before the edge. A config write in the same cycle as arbitration takes effect from the next cycle.
- Latency: request eligible in cycle k gives `oIRQ_SRC_ACK` in cycle k and `oIRQ_VALID` from cycle k+1.
- Handshake: `iIRQ_ACK` sampled in cycle m gives `oIRQ_VALID`=0 in m+1. The earliest next capture is in cycle m+1, so the next `oIRQ_VALID` rises in m+2.
- Requests raised or dropped during ACK_WAIT are not observed until IDLE.

## Configuration
- `DPS_IRQ_ARB_LEVEL_EN` defined: level priority, then round-robin, as above.
- `DPS_IRQ_ARB_LEVEL_EN` undefined:
  - Pure round-robin over eligible sources; levels are ignored for selection.
  - The level table field is not built and `oIRQ_LEVEL` is tied to 0.
  - `iCFG_LEVEL` is accepted and discarded.

## Structure
- Shared header `global.h`:
  - state encodings `DPS_IRQ_ARB_STT_IDLE`=1'b0 and `DPS_IRQ_ARB_STT_ACK_WAIT`=1'b1
  - the default `IRQ_N` constant
  - the existing `DATA_RESET_ENABLE`, which governs the level field reset
- Sub-module `dps_irq_arbiter_pick`: purely combinational.
  - Inputs: eligible vector, level vector, `rr_ptr`.
  - Outputs: winner valid, winner index, winner level.
  - The top level holds the table, state machine and pointer.

## Test plan
- Reset, then `iIRQ_REQ`=4'b0100 with the table at defaults:
  - `oIRQ_SRC_ACK`=4'b0100 in the same cycle.
  - Next cycle `oIRQ_VALID`=1, `oIRQ_NUM`=2.
  - `iIRQ_ACK` gives `oIRQ_VALID`=0 one cycle later.
- Configure entry 1 with valid=1, mask=0, then raise `iIRQ_REQ`=4'b0010 -> no `oIRQ_VALID` for 20 cycles. Rewrite entry 1 with mask=1 -> `oIRQ_NUM`=1 presented.
- With `DPS_IRQ_ARB_LEVEL_EN`: levels {0:1, 1:3, 2:3, 3:2} and `iIRQ_REQ`=4'b1111 held.
  - Successive grants are 1, 2, 1, 2.
  - `oIRQ_LEVEL`=3 each time.
- Without `DPS_IRQ_ARB_LEVEL_EN`, same setup -> grants 0, 1, 2, 3, 0 and `oIRQ_LEVEL`=0.
- In ACK_WAIT presenting source 2, write entry 2 with valid=1, mask=0 and raise source 3 -> `oIRQ_NUM` stays 2 until ack; then source 3 is granted.
- Assert `inRESET` while `oIRQ_VALID`=1 -> all outputs 0 immediately. After release with no requests, `oIRQ_VALID` stays 0.
